mem_access_unit: RTL

- Parametrised successor to the data/fetch memory block: load/store alignment unit between the CPU datapath and a dual-port word RAM with configurable read latency.
- Port A serves data loads/stores (byte, halfword, word, LWL/LWR, SWL/SWR) through a valid/ready handshake with explicit response valid; port B serves pipelined instruction fetch.
- Supersedes fixed-latency, handshake-less access; adds merge of LWL/LWR with rt, and optional alignment trapping.

---
 rtl/mem_access_unit_if.sv | 51 +++++
 rtl/mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : CPU-side bundle of mem_access_unit. It carries the data request
//           and response handshake (port A) and the instruction fetch
//           request and result (port B).
// Modports:
//   master - CPU datapath side: drives requests and fetches, receives
//            responses.
//   slave  - mem_access_unit side.
// Signals :
//   reqValid/reqReady       data request handshake
//   reqAddr                 byte address
//   reqWriteMode/ReadMode   access modes: 0 NONE, 1 BYTE, 2 HALFWORD,
//                           3 WORD, 4 WORDLEFT, 5 WORDRIGHT; 6/7 = NONE
//   reqUnsigned             zero-extend BYTE/HALFWORD loads
//   reqStoreData            store source (rt)
//   reqRtValue              old rt value, used by the LWL/LWR merge
//   respValid/respData      one-cycle load result strobe; data is held
//   addrError               one-cycle misalignment strobe
//   fetchReq/fetchAddr      pipelined instruction fetch request
//   fetchDataValid/fetchData  fetch result
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic [2:0]  reqWriteMode;
  logic [2:0]  reqReadMode;
  logic        reqUnsigned;
  logic [31:0] reqStoreData;
  logic [31:0] reqRtValue;
  logic        respValid;
  logic [31:0] respData;
  logic        addrError;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchDataValid;
  logic [31:0] fetchData;

  modport master (
    output reqValid, reqAddr, reqWriteMode, reqReadMode, reqUnsigned,
           reqStoreData, reqRtValue, fetchReq, fetchAddr,
    input  reqReady, respValid, respData, addrError, fetchDataValid, fetchData
  );

  modport slave (
    input  reqValid, reqAddr, reqWriteMode, reqReadMode, reqUnsigned,
           reqStoreData, reqRtValue, fetchReq, fetchAddr,
    output reqReady, respValid, respData, addrError, fetchDataValid, fetchData
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Purpose : Load/store alignment unit between the CPU datapath and a
//           dual-port word RAM with a read latency of RAM_LATENCY cycles.
//           Port A handles byte/halfword/word and LWL/LWR/SWL/SWR accesses
//           through a valid/ready handshake; port B handles fully pipelined
//           instruction fetch.
// Parameters:
//   ADDR_WIDTH  - byte-address bits used (RAM word address is ADDR_WIDTH-2)
//   RAM_LATENCY - RAM read latency in cycles, 1..4
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   bus         - CPU-side request/response/fetch bundle (slave modport)
//   ramA*       - RAM port A command (combinational in the accept cycle)
//                 and read data
//   ramB*       - RAM port B fetch command and read data
// Build option:
//   ALIGN_TRAP_EN - when defined, misaligned HALFWORD/WORD accesses are
//                   dropped and reported on addrError. When undefined, the
//                   offending low address bits are forced to alignment and
//                   addrError is always 0.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus,
  output logic [ADDR_WIDTH-3:0] ramAAddr,
  output logic [3:0]            ramAByteEn,
  output logic [31:0]           ramAWrData,
  output logic                  ramAWrEn,
  output logic                  ramARdEn,
  input  logic [31:0]           ramARdData,
  output logic [ADDR_WIDTH-3:0] ramBAddr,
  output logic                  ramBRdEn,
  input  logic [31:0]           ramBRdData
);

  localparam logic [2:0] MODE_NONE   = 3'd0;
  localparam logic [2:0] MODE_BYTE   = 3'd1;
  localparam logic [2:0] MODE_HALF   = 3'd2;
  localparam logic [2:0] MODE_WORD   = 3'd3;
  localparam logic [2:0] MODE_WLEFT  = 3'd4;
  localparam logic [2:0] MODE_WRIGHT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_data_q, resp_data_d;
  logic                   addr_error_q, addr_error_d;
  logic [1:0]             ld_off_q, ld_off_d;
  logic [2:0]             ld_mode_q, ld_mode_d;
  logic                   ld_unsigned_q, ld_unsigned_d;
  logic [31:0]            ld_rt_q, ld_rt_d;
  logic [RAM_LATENCY-1:0] fetch_pipe_q, fetch_pipe_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic [31:0]            fetch_data_q, fetch_data_d;

  logic       accept;
  logic       wr_active;
  logic       rd_active;
  logic       trap;
  logic       wr_fire;
  logic       rd_fire;
  logic [2:0] active_mode;
  logic [1:0] off;
  logic [1:0] eff_off;

  // Address bits above ADDR_WIDTH and the fetch byte offset are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.reqAddr[31:ADDR_WIDTH],
                              bus.fetchAddr[31:ADDR_WIDTH],
                              bus.fetchAddr[1:0]};

  // Formats a RAM word into the load result. For WORDLEFT/WORDRIGHT the
  // bytes not supplied by memory keep the old rt value; 3-off equals ~off
  // for a 2-bit offset.
  function automatic logic [31:0] format_load(
    input logic [2:0]  mode,
    input logic [1:0]  o,
    input logic        uns,
    input logic [31:0] rt,
    input logic [31:0] q
  );
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] result;
    shifted = q >> {o, 3'b000};
    b       = shifted[7:0];
    h       = o[1] ? q[31:16] : q[15:0];
    result  = q;
    case (mode)
      MODE_BYTE:   result = uns ? {24'h0, b} : {{24{b[7]}}, b};
      MODE_HALF:   result = uns ? {16'h0, h} : {{16{h[15]}}, h};
      MODE_WORD:   result = q;
      MODE_WLEFT:  result = (q << {~o, 3'b000}) |
                            (rt & ~(32'hFFFF_FFFF << {~o, 3'b000}));
      MODE_WRIGHT: result = (q >> {o, 3'b000}) |
                            (rt & ~(32'hFFFF_FFFF >> {o, 3'b000}));
      default:     result = q;
    endcase
    return result;
  endfunction

  // Request decode: a valid write mode wins over the read mode, and codes
  // 6/7 behave as NONE. The effective offset is what the access really uses
  // after alignment handling.
  always_comb begin
    off         = bus.reqAddr[1:0];
    accept      = bus.reqValid & req_ready_q;
    wr_active   = (bus.reqWriteMode != MODE_NONE) && (bus.reqWriteMode <= MODE_WRIGHT);
    rd_active   = !wr_active && (bus.reqReadMode != MODE_NONE) &&
                  (bus.reqReadMode <= MODE_WRIGHT);
    active_mode = wr_active ? bus.reqWriteMode : (rd_active ? bus.reqReadMode : MODE_NONE);
`ifdef ALIGN_TRAP_EN
    eff_off = off;
    trap    = ((active_mode == MODE_HALF) && off[0]) ||
              ((active_mode == MODE_WORD) && (off != 2'b00));
`else
    trap = 1'b0;
    case (active_mode)
      MODE_HALF: eff_off = {off[1], 1'b0};
      MODE_WORD: eff_off = 2'b00;
      default:   eff_off = off;
    endcase
`endif
    wr_fire = accept & wr_active & ~trap;
    rd_fire = accept & rd_active & ~trap;
  end

  // RAM port A command, driven in the accept cycle itself. Stores complete
  // here; WORDLEFT writes the top bytes of rt into the low end of the word,
  // WORDRIGHT the low bytes of rt into the high end.
  always_comb begin
    ramAAddr   = bus.reqAddr[ADDR_WIDTH-1:2];
    ramAWrEn   = wr_fire;
    ramARdEn   = rd_fire;
    ramAByteEn = 4'b0000;
    ramAWrData = 32'h0;
    if (wr_fire) begin
      case (active_mode)
        MODE_BYTE: begin
          ramAByteEn = 4'b0001 << eff_off;
          ramAWrData = bus.reqStoreData << {eff_off, 3'b000};
        end
        MODE_HALF: begin
          ramAByteEn = 4'b0011 << eff_off;
          ramAWrData = bus.reqStoreData << {eff_off, 3'b000};
        end
        MODE_WORD: begin
          ramAByteEn = 4'b1111;
          ramAWrData = bus.reqStoreData;
        end
        MODE_WLEFT: begin
          ramAByteEn = 4'b1111 >> (~eff_off);
          ramAWrData = bus.reqStoreData >> {~eff_off, 3'b000};
        end
        MODE_WRIGHT: begin
          ramAByteEn = 4'b1111 << eff_off;
          ramAWrData = bus.reqStoreData << {eff_off, 3'b000};
        end
        default: begin
          ramAByteEn = 4'b0000;
          ramAWrData = 32'h0;
        end
      endcase
    end
  end

  // Load FSM next state. A load holds reqReady low for RAM_LATENCY cycles,
  // formats the RAM word on the last of them and presents it one cycle
  // later. RESP behaves like IDLE so a new request can be accepted while the
  // previous result is on respValid.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    addr_error_d  = accept & trap;
    ld_off_d      = ld_off_q;
    ld_mode_d     = ld_mode_q;
    ld_unsigned_d = ld_unsigned_q;
    ld_rt_d       = ld_rt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (rd_fire) begin
          state_d       = S_WAIT;
          cnt_d         = 2'(RAM_LATENCY - 1);
          req_ready_d   = 1'b0;
          ld_off_d      = eff_off;
          ld_mode_d     = bus.reqReadMode;
          ld_unsigned_d = bus.reqUnsigned;
          ld_rt_d       = bus.reqRtValue;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          req_ready_d  = 1'b1;
          resp_data_d  = format_load(ld_mode_q, ld_off_q, ld_unsigned_q, ld_rt_q, ramARdData);
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // Fetch pipeline: one valid bit per cycle of RAM latency, then the RAM
  // word is registered into fetchData, which holds between results.
  always_comb begin
    ramBRdEn        = bus.fetchReq;
    ramBAddr        = bus.fetchAddr[ADDR_WIDTH-1:2];
    fetch_pipe_d    = fetch_pipe_q << 1;
    fetch_pipe_d[0] = bus.fetchReq;
    fetch_valid_d   = fetch_pipe_q[RAM_LATENCY-1];
    fetch_data_d    = fetch_pipe_q[RAM_LATENCY-1] ? ramBRdData : fetch_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 32'h0;
      addr_error_q  <= 1'b0;
      ld_off_q      <= 2'b00;
      ld_mode_q     <= MODE_NONE;
      ld_unsigned_q <= 1'b0;
      ld_rt_q       <= 32'h0;
      fetch_pipe_q  <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      addr_error_q  <= addr_error_d;
      ld_off_q      <= ld_off_d;
      ld_mode_q     <= ld_mode_d;
      ld_unsigned_q <= ld_unsigned_d;
      ld_rt_q       <= ld_rt_d;
      fetch_pipe_q  <= fetch_pipe_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  assign bus.reqReady       = req_ready_q;
  assign bus.respValid      = resp_valid_q;
  assign bus.respData       = resp_data_q;
  assign bus.addrError      = addr_error_q;
  assign bus.fetchDataValid = fetch_valid_q;
  assign bus.fetchData      = fetch_data_q;

endmodule
